uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 9, clocks per UART bit (27 MHz / 3 Mbps); legal range 4..255.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, LSB first; legal range 5..8.
REQ-003 SHALL have parameter FIFO_AW, default 2, log2 of receive FIFO depth (default depth 4).
REQ-004 SHALL have parameter TIMEOUT_CLKS, default 20, idle clocks before block_timeout fires; legal range 1..65535.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port rd_en, input, 1, pop request for the FIFO head.
REQ-009 SHALL have port rd_data, output, DATA_BITS, FIFO head, first-word fall-through.
REQ-010 SHALL have port rd_valid, output, 1, FIFO not empty.
REQ-011 SHALL have port rx_bsy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port block_timeout, output, 1, one-clock pulse at end of a received block.
REQ-013 SHALL have port frame_err, output, 1, one-clock pulse on a bad stop bit.
REQ-014 SHALL have port overrun, output, 1, one-clock pulse when a byte is dropped because the FIFO is full.
REQ-015 SHALL have port parity_err, output, 1, one-clock pulse on a parity mismatch.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; a bit counter runs 0..CLKS_PER_BIT-1 and wraps.
REQ-018 SHALL leave IDLE for START on a synchronized 1->0 edge, clearing the bit counter.
REQ-019 SHALL take each bit value as the majority of 3 samples at counts M-1, M, M+1, where M = CLKS_PER_BIT/2 (integer division).
REQ-020 SHALL, when the START majority is 1, return to IDLE with no pulse (glitch reject); otherwise go to DATA at the bit boundary.
REQ-021 SHALL shift in DATA_BITS bits LSB first, then go to PARITY if enabled, otherwise to STOP.
REQ-022 SHALL decide the frame at STOP count M+1 and return to IDLE on the next clock; it SHALL NOT wait for the full stop bit.
REQ-023 SHALL, on a STOP majority of 0, pulse frame_err and discard the byte.
REQ-024 SHALL, on a good stop bit with the FIFO not full, push the byte; rd_valid rises the clock after the push.
REQ-025 SHALL, on a good stop bit with the FIFO full and no pop in the same clock, pulse overrun, drop the new byte, and leave FIFO contents unchanged.
REQ-026 SHALL, when a push and a pop occur in the same clock on a full FIFO, perform both with no overrun.
REQ-027 SHALL, on rd_en while rd_valid is high, advance the head on the next clock; rd_en while empty is ignored.
REQ-028 SHALL wrap FIFO pointers modulo 2^FIFO_AW and track fill level in a FIFO_AW+1-bit count.
REQ-029 SHALL count consecutive IDLE clocks and pulse block_timeout once when the count reaches TIMEOUT_CLKS, but only if at least one frame ended (good or bad) since the previous pulse.
REQ-030 SHALL reset the idle count on leaving IDLE and saturate it after the pulse.

Reset
REQ-031 SHALL, while rst=0 at a clock edge: state=IDLE; counters, FIFO pointers and fill level=0; rd_valid=0; rd_data=0; rx_bsy, block_timeout, frame_err, overrun and parity_err all 0.
REQ-032 SHALL, on reset mid-frame, abandon the partial byte and discard FIFO contents; after release, the first frame is recognized only after a new falling edge.

Configuration
REQ-033 SHALL, with macro UART_RX_PARITY_EN defined, include state PARITY: one even-parity bit after the data bits; on mismatch pulse parity_err at the STOP decision and discard the byte, with frame_err taking precedence.
REQ-034 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and logic and tie parity_err to 0.

Verification (CLKS_PER_BIT=9, DATA_BITS=8, FIFO_AW=2, TIMEOUT_CLKS=20)
REQ-035 SHALL verify: frame 0xA5 with a good stop bit -> rd_valid=1, rd_data=0xA5; after one rd_en, rd_valid=0.
REQ-036 SHALL verify: 2-clock low glitch on an idle line -> no push, no pulses, rx_bsy back to 0 within 8 clocks.
REQ-037 SHALL verify: frame 0x3C with a low stop bit -> one frame_err pulse, rd_valid stays 0.
REQ-038 SHALL verify: frames 0x01..0x05 with no reads -> one overrun pulse on 0x05; pops return 0x01, 0x02, 0x03, 0x04.
REQ-039 SHALL verify: 0x11 then 20 idle clocks -> exactly one block_timeout pulse; 100 more idle clocks -> no further pulse.
REQ-040 SHALL verify: with UART_RX_PARITY_EN, 0x03 with parity bit 1 -> parity_err pulse and no push; with parity bit 0 -> push 0x03.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with 3-sample majority voting and a first-word fall-through receive FIFO
// Defining UART_RX_PARITY_EN adds one even-parity bit after the data bits.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 9,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_AW      = 2,
  parameter int TIMEOUT_CLKS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rx_bsy,
  output logic                 block_timeout,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);
  localparam int                DEPTH    = 1 << FIFO_AW;
  localparam logic [7:0]        MID      = 8'(CLKS_PER_BIT / 2);
  localparam logic [7:0]        LAST     = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [15:0]       TO       = 16'(TIMEOUT_CLKS);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]  CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]  CNT_FULL = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [7:0]           cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           smp_q;
  logic [15:0]          idle_q;
  logic                 armed_q;
  logic                 frame_err_q, overrun_q, block_timeout_q;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q;

  logic fall, maj, decide, par_bad, good_d, pop_d, push_d, overrun_d, full;

  assign fall = rx_prev_q & ~rx_s2_q;
  // third vote is the live synchronized sample at count M+1
  assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q) | (smp_q[1] & rx_s2_q);
  assign decide = (state_q == STOP) && (cnt_q == MID + 8'd1);

`ifdef UART_RX_PARITY_EN
  logic par_q, parity_err_q;
  assign par_bad    = par_q ^ (^shift_q);
  assign parity_err = parity_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign full      = (count_q == CNT_FULL);
  assign pop_d     = rd_en && (count_q != '0);
  assign good_d    = decide && maj && !par_bad;
  assign push_d    = good_d && (!full || pop_d);
  assign overrun_d = good_d && full && !pop_d;

  assign rd_valid      = (count_q != '0);
  assign rd_data       = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rx_bsy        = (state_q != IDLE);
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign block_timeout = block_timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      rx_s1_q         <= 1'b1;
      rx_s2_q         <= 1'b1;
      rx_prev_q       <= 1'b1;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      smp_q           <= '0;
      idle_q          <= '0;
      armed_q         <= 1'b0;
      frame_err_q     <= 1'b0;
      overrun_q       <= 1'b0;
      block_timeout_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q           <= 1'b0;
      parity_err_q    <= 1'b0;
`endif
    end else begin
      rx_s1_q         <= rx;
      rx_s2_q         <= rx_s1_q;
      rx_prev_q       <= rx_s2_q;
      frame_err_q     <= 1'b0;
      block_timeout_q <= 1'b0;
      overrun_q       <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q    <= 1'b0;
`endif
      if (state_q != IDLE) cnt_q <= (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
      if (cnt_q == MID - 8'd1) smp_q[0] <= rx_s2_q;
      if (cnt_q == MID) smp_q[1] <= rx_s2_q;

      case (state_q)
        IDLE: if (fall) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: begin
          if (cnt_q == MID + 8'd1 && maj) state_q <= IDLE;
          else if (cnt_q == LAST) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (cnt_q == MID + 8'd1) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          if (cnt_q == LAST) begin
`ifdef UART_RX_PARITY_EN
            if (bit_idx_q == LAST_BIT) state_q <= PARITY;
`else
            if (bit_idx_q == LAST_BIT) state_q <= STOP;
`endif
            else bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == MID + 8'd1) par_q <= maj;
          if (cnt_q == LAST) state_q <= STOP;
        end
`endif
        STOP: if (decide) begin
          state_q     <= IDLE;
          armed_q     <= 1'b1;
          frame_err_q <= !maj;
`ifdef UART_RX_PARITY_EN
          parity_err_q <= maj && par_bad;
`endif
        end
        default: state_q <= IDLE;
      endcase

      // idle count saturates at TO; a new falling edge restarts it
      if (state_q == IDLE && !fall) begin
        if (idle_q != TO) begin
          idle_q <= idle_q + 16'd1;
          if (idle_q + 16'd1 == TO && armed_q) begin
            block_timeout_q <= 1'b1;
            armed_q         <= 1'b0;
          end
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_d) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_d, pop_d})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_d) mem_q[wr_ptr_q] <= shift_q;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - frame-level scoreboard bench for uart_rx_fifo
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_fifo;
  localparam int C     = 9;
  localparam int DB    = 8;
  localparam int AW    = 2;
  localparam int TO    = 20;
  localparam int M     = C / 2;
  localparam int DEPTH = 1 << AW;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 1 + DB + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 1 + DB;
  localparam bit PAR = 1'b0;
`endif
  // start bit driven after edge t0 -> stop decision visible after edge t0+LAT
  localparam int LAT = NB * C + M + 5;

  logic clk = 1'b0, rst = 1'b0, rx = 1'b1, rd_en = 1'b0;
  logic [DB-1:0] rd_data;
  logic rd_valid, rx_bsy, block_timeout, frame_err, overrun, parity_err;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .FIFO_AW(AW), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rx_bsy(rx_bsy), .block_timeout(block_timeout), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, bt_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [7:0] mq[$];
  bit busy = 0, armed = 0, act_valid = 0, act_frame = 0, act_stop = 0, act_par = 0;
  int act_start = 0, act_end = 0, idle_start = 0;
  logic [7:0] act_data = '0;
  bit rd_en_s = 0, rst_s = 0;

  always @(negedge clk) begin
    bit popped, full, e_fe, e_ov, e_pe, e_bt;
    popped = 0; full = 0; e_fe = 0; e_ov = 0; e_pe = 0; e_bt = 0;
    if (!rst_s) begin
      mq.delete();
      busy = 0; armed = 0; act_valid = 0; idle_start = cyc;
      chk("rst_rd_data", rd_data, 0);
    end else begin
      popped = rd_en_s && (mq.size() > 0);
      full   = (mq.size() == DEPTH);
      if (act_valid && cyc == act_start) busy = 1;
      if (act_valid && cyc == act_end) begin
        busy = 0; idle_start = cyc; act_valid = 0;
        if (act_frame) begin
          armed = 1;
          if (!act_stop) e_fe = 1;
          else if (PAR && !act_par) e_pe = 1;
          else if (full && !popped) e_ov = 1;
          else begin
            if (popped) begin void'(mq.pop_front()); popped = 0; end
            mq.push_back(act_data);
          end
        end
      end
      if (popped) void'(mq.pop_front());
      if (!busy && armed && (cyc - idle_start == TO)) begin e_bt = 1; armed = 0; end
    end
    chk("rd_valid", rd_valid, mq.size() > 0);
    if (mq.size() > 0) chk("rd_data", rd_data, mq[0]);
    chk("rx_bsy", rx_bsy, busy);
    chk("frame_err", frame_err, e_fe);
    chk("parity_err", parity_err, e_pe);
    chk("overrun", overrun, e_ov);
    chk("block_timeout", block_timeout, e_bt);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (parity_err) pe_cnt++;
    if (block_timeout) bt_cnt++;
    rd_en_s = rd_en;
    rst_s   = rst;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int gap);
    @(posedge clk); #1;
    act_start = cyc + 3; act_end = cyc + LAT; act_frame = 1; act_data = d;
    act_stop = stop_ok; act_par = par_ok; act_valid = 1;
    rx = 1'b0; tick(C);
    for (int i = 0; i < DB; i++) begin rx = d[i]; tick(C); end
    if (PAR) begin rx = (^d) ^ !par_ok; tick(C); end
    rx = stop_ok; tick(C);
    rx = 1'b1; tick(gap);
  endtask

  task automatic glitch();
    @(posedge clk); #1;
    act_start = cyc + 3; act_end = cyc + M + 5; act_frame = 0; act_valid = 1;
    rx = 1'b0; tick(2);
    rx = 1'b1; tick(8);
    chk("glitch_bsy_clear", rx_bsy, 0);
    tick(2);
  endtask

  task automatic pop_expect(input logic [7:0] e, input string nm);
    chk({nm, "_valid"}, rd_valid, 1);
    chk(nm, rd_data, e);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask

  int rd_pct = 0;
  bit rand_on = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_on) rd_en = ($urandom_range(0, 99) < rd_pct);
  end

  int f0, o0, b0, r;
  initial begin
    tick(4);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rx_bsy", rx_bsy, 0);
    rst = 1'b1; tick(5);

    send_frame(8'hA5, 1, 1, 3);
    pop_expect(8'hA5, "a5_data");
    chk("a5_empty_after_pop", rd_valid, 0);

    glitch();
    chk("glitch_no_push", rd_valid, 0);

    f0 = fe_cnt;
    send_frame(8'h3C, 0, 1, 3);
    chk("3c_frame_err_count", fe_cnt - f0, 1);
    chk("3c_no_push", rd_valid, 0);

    o0 = ov_cnt;
    for (int v = 1; v <= 4; v++) send_frame(8'(v), 1, 1, 2);
    chk("ov_none_before_5", ov_cnt - o0, 0);
    send_frame(8'h05, 1, 1, 2);
    chk("ov_on_5", ov_cnt - o0, 1);
    for (int v = 1; v <= 4; v++) pop_expect(8'(v), "ov_pop");
    chk("ov_drained", rd_valid, 0);

    o0 = ov_cnt;
    for (int v = 'h41; v <= 'h44; v++) send_frame(8'(v), 1, 1, 2);
    fork
      send_frame(8'h45, 1, 1, 3);
      begin @(posedge clk); #1; tick(LAT - 1); rd_en = 1'b1; tick(1); rd_en = 1'b0; end
    join
    chk("full_push_pop_no_ov", ov_cnt - o0, 0);
    for (int v = 'h42; v <= 'h45; v++) pop_expect(8'(v), "full_pp_pop");

    tick(150);
    b0 = bt_cnt;
    send_frame(8'h11, 1, 1, 1);
    tick(25);
    chk("bt_once", bt_cnt - b0, 1);
    tick(100);
    chk("bt_saturated", bt_cnt - b0, 1);
    pop_expect(8'h11, "bt_data");

    send_frame(8'h22, 1, 1, 2);
    send_frame(8'h33, 1, 1, 2);
    @(posedge clk); #1;
    act_start = cyc + 3; act_end = 32'h7fff_ffff; act_frame = 0; act_valid = 1;
    rx = 1'b0; tick(C); rx = 1'b1; tick(C); rx = 1'b0; tick(4);
    rst = 1'b0; rx = 1'b1; tick(3);
    chk("midrst_bsy", rx_bsy, 0);
    chk("midrst_fifo_cleared", rd_valid, 0);
    rst = 1'b1; tick(12);
    chk("midrst_no_false_frame", rd_valid, 0);
    send_frame(8'h5A, 1, 1, 3);
    pop_expect(8'h5A, "after_rst");

`ifdef UART_RX_PARITY_EN
    f0 = pe_cnt;
    send_frame(8'h03, 1, 0, 3);
    chk("par_err_count", pe_cnt - f0, 1);
    chk("par_err_no_push", rd_valid, 0);
    send_frame(8'h03, 1, 1, 3);
    pop_expect(8'h03, "par_good");
`endif

    rand_on = 1;
    for (int it = 0; it < 60; it++) begin
      rd_pct = (it < 30) ? 1 : 25;
      r = $urandom_range(0, 9);
      if (r == 0) glitch();
      else send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0,
                      $urandom_range(0, 6) != 0,
                      (r == 1) ? $urandom_range(25, 40) : $urandom_range(1, 4));
    end
    rand_on = 0; tick(1); rd_en = 1'b0;
    tick(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
